// File: rtl/mbssoc_apic.sv
// rtl/mbssoc_apic.sv - dual-core boot PC and reset sequencer
module mbssoc_apic #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    HOLD_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] BOOT_PC0    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            ctrl_bus,
  input  logic [DATA_WIDTH-1:0] data_bus,
  output logic [1:0]            cpu_rst_n,
  output logic [1:0]            cpu_pc_load,
  output logic [DATA_WIDTH-1:0] boot_pc0,
  output logic [DATA_WIDTH-1:0] boot_pc1,
  output logic [7:0]            status
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } core_state_e;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

  // strobe history holds {core1 pc, core0 pc, conf}
  logic [2:0]            strobe_q, strobe_d;
  logic [2:0]            strobe_rise;
  core_state_e           state_q [2];
  core_state_e           state_d [2];
  logic [3:0]            cnt_q [2];
  logic [3:0]            cnt_d [2];
  logic [DATA_WIDTH-1:0] pc_q [2];
  logic [DATA_WIDTH-1:0] pc_d [2];
  logic [1:0]            pcv_q, pcv_d;
  logic [1:0]            err_q, err_d;
  logic                  conf_wr;
  logic [1:0]            pc_wr;
  logic [1:0]            start_cmd;
  logic [1:0]            halt_cmd;
  logic                  clr_err;
  logic [1:0]            err_set;
  logic                  unused_bits;

  // RAM strobes and upper conf bits carry nothing for this block
  assign unused_bits = ^{ctrl_bus[1:0], data_bus[DATA_WIDTH-1:5]};

  // edge-detect strobes, decode commands and advance both core FSMs
  always_comb begin
    strobe_d    = ctrl_bus[4:2];
    strobe_rise = ctrl_bus[4:2] & ~strobe_q;
    conf_wr     = strobe_rise[0];
    pc_wr       = strobe_rise[2:1];
    start_cmd   = data_bus[1:0] & {2{conf_wr}};
    halt_cmd    = data_bus[3:2] & {2{conf_wr}};
    clr_err     = data_bus[4] & conf_wr;
    err_set     = 2'b00;
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      pc_d[n]    = pc_wr[n] ? data_bus : pc_q[n];
      case (state_q[n])
        ST_HALT: begin
          // halt beats start; start checks the pcv value held before this edge
          if (start_cmd[n] && !halt_cmd[n]) begin
            if (pcv_q[n]) begin
              state_d[n] = ST_HOLD;
              cnt_d[n]   = HOLD_INIT;
            end else begin
              err_set[n] = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (halt_cmd[n]) begin
            state_d[n] = ST_HALT;
          end else if (cnt_q[n] <= 4'd1) begin
            state_d[n] = ST_RUN;
            cnt_d[n]   = 4'd0;
          end else begin
            cnt_d[n] = cnt_q[n] - 4'd1;
          end
        end
        ST_RUN: begin
          if (halt_cmd[n]) state_d[n] = ST_HALT;
        end
        default: state_d[n] = ST_HALT;
      endcase
    end
    pcv_d = pcv_q | pc_wr;
    err_d = (err_q & ~{2{clr_err}}) | err_set;
  end

  // state registers; reset leaves core0 booting and core1 parked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q   <= 3'b000;
      state_q[0] <= ST_HOLD;
      state_q[1] <= ST_HALT;
      cnt_q[0]   <= HOLD_INIT;
      cnt_q[1]   <= 4'd0;
      pc_q[0]    <= BOOT_PC0;
      pc_q[1]    <= '0;
      pcv_q      <= 2'b01;
      err_q      <= 2'b00;
    end else begin
      strobe_q   <= strobe_d;
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      pc_q[0]    <= pc_d[0];
      pc_q[1]    <= pc_d[1];
      pcv_q      <= pcv_d;
      err_q      <= err_d;
    end
  end

  // outputs are direct decodes of the state registers
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cpu_rst_n[n]   = (state_q[n] == ST_RUN);
      cpu_pc_load[n] = (state_q[n] == ST_HOLD);
    end
    boot_pc0 = pc_q[0];
    boot_pc1 = pc_q[1];
    status   = {err_q, pcv_q, cpu_rst_n, cpu_pc_load};
  end

endmodule

// File: tb/tb_mbssoc_apic.sv
// tb/tb_mbssoc_apic.sv - self-checking bench for mbssoc_apic
module tb_mbssoc_apic;

  localparam int          HC  = 4;
  localparam logic [31:0] BPC = 32'h0000_0100;
  localparam int M_HALT = 0, M_HOLD = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ctrl_bus = 5'd0;
  logic [31:0] data_bus = 32'd0;
  logic [1:0]  cpu_rst_n, cpu_pc_load;
  logic [31:0] boot_pc0, boot_pc1;
  logic [7:0]  status;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: per-core mode plus cycles spent holding
  int          m_mode [2];
  int          m_age [2];
  logic [31:0] m_pc [2];
  logic [1:0]  m_pcv, m_err;
  logic [2:0]  m_prev;

  mbssoc_apic #(.DATA_WIDTH(32), .HOLD_CYCLES(HC), .BOOT_PC0(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_bus(ctrl_bus), .data_bus(data_bus),
    .cpu_rst_n(cpu_rst_n), .cpu_pc_load(cpu_pc_load),
    .boot_pc0(boot_pc0), .boot_pc1(boot_pc1), .status(status)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_mode[0] = M_HOLD; m_age[0] = 0; m_pc[0] = BPC;
    m_mode[1] = M_HALT; m_age[1] = 0; m_pc[1] = 32'd0;
    m_pcv = 2'b01; m_err = 2'b00; m_prev = 3'b000;
  endtask

  task automatic model_edge();
    logic [2:0] rise;
    logic [4:0] d;
    logic [1:0] old_pcv;
    rise = ctrl_bus[4:2] & ~m_prev;
    m_prev = ctrl_bus[4:2];
    d = data_bus[4:0];
    old_pcv = m_pcv;
    if (rise[0] && d[4]) m_err = 2'b00;
    for (int n = 0; n < 2; n++) begin
      if (rise[0] && d[n+2]) begin
        m_mode[n] = M_HALT;
      end else if (m_mode[n] == M_HALT && rise[0] && d[n]) begin
        if (old_pcv[n]) begin
          m_mode[n] = M_HOLD; m_age[n] = 0;
        end else begin
          m_err[n] = 1'b1;
        end
      end else if (m_mode[n] == M_HOLD) begin
        m_age[n]++;
        if (m_age[n] >= HC) m_mode[n] = M_RUN;
      end
      if (rise[n+1]) begin
        m_pc[n] = data_bus; m_pcv[n] = 1'b1;
      end
    end
  endtask

  function automatic logic [75:0] mdl();
    logic [1:0] r, h;
    for (int n = 0; n < 2; n++) begin
      r[n] = (m_mode[n] == M_RUN);
      h[n] = (m_mode[n] == M_HOLD);
    end
    return {r, h, m_err, m_pcv, r, h, m_pc[0], m_pc[1]};
  endfunction

  function automatic logic [75:0] obs();
    return {cpu_rst_n, cpu_pc_load, status, boot_pc0, boot_pc1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; ctrl_bus = 5'd0; data_bus = 32'd0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int hi;
    #23;
    m_reset();
    n_cmp++;
    if (status !== 8'h11 || cpu_rst_n !== 2'b00 || cpu_pc_load !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%h rst=%b pcl=%b want st=11 rst=00 pcl=01", status, cpu_rst_n, cpu_pc_load);
    end
    n_cmp++;
    if (boot_pc0 !== BPC || boot_pc1 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pcs: got %h/%h want %h/0", boot_pc0, boot_pc1, BPC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_pc_load[0]) hi++;
      step();
    end
    n_cmp++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL reset_hold_len: got %0d want 4", hi);
    end
    n_cmp++;
    if (cpu_rst_n !== 2'b01 || status !== 8'h14) begin
      n_fail++;
      $display("FAIL reset_run: got rst=%b st=%h want 01/14", cpu_rst_n, status);
    end
  endtask

  task automatic test_core1_boot();
    int hi;
    do_reset();
    ctrl_bus = 5'b10000; data_bus = 32'h0000_1000;
    step();
    ctrl_bus = 5'd0;
    step();
    n_cmp++;
    if (boot_pc1 !== 32'h1000) begin
      n_fail++;
      $display("FAIL core1_pc: got %h want 00001000", boot_pc1);
    end
    ctrl_bus = 5'b00100; data_bus = 32'h2;
    step();
    ctrl_bus = 5'd0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_pc_load[1] && !cpu_rst_n[1]) hi++;
      if (i == 1) begin ctrl_bus = 5'b10000; data_bus = 32'h0000_2000; end
      step();
      ctrl_bus = 5'd0;
    end
    n_cmp++;
    if (hi !== 4) begin
      n_fail++;
      $display("FAIL core1_hold_len: got %0d want 4", hi);
    end
    n_cmp++;
    if (status !== 8'h3C || cpu_rst_n !== 2'b11 || boot_pc1 !== 32'h2000) begin
      n_fail++;
      $display("FAIL core1_run: got st=%h rst=%b pc1=%h want 3c/11/00002000", status, cpu_rst_n, boot_pc1);
    end
    n_cmp++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL core1_model: got %h want %h", obs(), mdl());
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (cpu_rst_n !== 2'b00 || cpu_pc_load !== 2'b01 || status !== 8'h11 || boot_pc1 !== 32'd0 || boot_pc0 !== BPC) begin
      n_fail++;
      $display("FAIL async_reset: got rst=%b pcl=%b st=%h pc0=%h pc1=%h want 00/01/11/%h/0",
               cpu_rst_n, cpu_pc_load, status, boot_pc0, boot_pc1, BPC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (cpu_rst_n !== 2'b01 || status !== 8'h14) begin
      n_fail++;
      $display("FAIL async_rerun: got rst=%b st=%h want 01/14", cpu_rst_n, status);
    end
  endtask

  task automatic test_err();
    do_reset();
    ctrl_bus = 5'b00100; data_bus = 32'h2;
    step();
    ctrl_bus = 5'd0;
    n_cmp++;
    if (status[7] !== 1'b1 || cpu_rst_n[1] !== 1'b0 || cpu_pc_load[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: got st=%h rst=%b pcl=%b want err1=1 core1 halted", status, cpu_rst_n, cpu_pc_load);
    end
    step();
    ctrl_bus = 5'b00100; data_bus = 32'h10;
    step();
    ctrl_bus = 5'd0;
    n_cmp++;
    if (status[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got st=%h want err1=0", status);
    end
  endtask

  task automatic test_held_strobe();
    int hi;
    do_reset();
    ctrl_bus = 5'b00100; data_bus = 32'h4;
    step();
    ctrl_bus = 5'd0;
    step();
    n_cmp++;
    if (cpu_rst_n[0] !== 1'b0 || cpu_pc_load[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL held_halt0: got rst=%b pcl=%b want core0 halted", cpu_rst_n, cpu_pc_load);
    end
    ctrl_bus = 5'b00100; data_bus = 32'h1;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 5) ctrl_bus = 5'd0;
      if (cpu_pc_load[0]) hi++;
    end
    n_cmp++;
    if (hi !== 4 || cpu_rst_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL held_strobe: got hold=%0d run0=%b want 4/1", hi, cpu_rst_n[0]);
    end
  endtask

  task automatic test_halt_wins();
    ctrl_bus = 5'b00100; data_bus = 32'h5;
    step();
    ctrl_bus = 5'd0;
    n_cmp++;
    if (cpu_rst_n[0] !== 1'b0 || status[6] !== 1'b0 || status[2] !== 1'b0 || status[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_wins: got rst=%b st=%h want core0 halted err0=0", cpu_rst_n, status);
    end
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctrl_bus = 5'b10100; data_bus = 32'h2;
    step();
    ctrl_bus = 5'd0;
    n_cmp++;
    if (status !== 8'hB1 || boot_pc1 !== 32'h2) begin
      n_fail++;
      $display("FAIL same_cycle: got st=%h pc1=%h want b1/00000002", status, boot_pc1);
    end
    step();
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        step();
        rst_n = 1'b1;
      end
      ctrl_bus = ($urandom_range(2) == 0) ? 5'($urandom) : 5'd0;
      data_bus = $urandom;
      step();
      n_cmp++;
      if (obs() !== mdl()) begin
        n_fail++;
        bad++;
        if (bad <= 5) $display("FAIL random cyc %0d: got %h want %h", i, obs(), mdl());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_core1_boot();
    test_async_reset();
    test_err();
    test_held_strobe();
    test_halt_wins();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
